// File: rtl/fft_stream_framer.sv
// Frames a sample stream into N-point transforms for a streaming FFT/IFFT core and indexes/checks
// the core output stream. Define FFT_FRAME_PAD_EN to zero-pad gap-aborted frames instead of dropping them.
module fft_stream_framer #(
  parameter int DW      = 8,
  parameter int LOG2N   = 10,
  parameter int GAP_MAX = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_real,
  input  logic [DW-1:0]    in_imag,
  input  logic             inverse,
  output logic             core_valid,
  output logic             core_sop,
  output logic             core_eop,
  output logic [DW-1:0]    core_real,
  output logic [DW-1:0]    core_imag,
  output logic             core_inverse,
  input  logic             core_ready,
  input  logic             src_valid,
  input  logic             src_sop,
  input  logic             src_eop,
  output logic [LOG2N-1:0] out_idx,
  output logic [LOG2N-1:0] in_idx,
  output logic             frame_err,
  output logic [15:0]      frames_done
);
  localparam logic [LOG2N-1:0] LAST_IDX = '1;
  localparam logic [7:0]       GAP_LAST = 8'(GAP_MAX - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAD} state_t;

  state_t           state, state_next;
  logic [LOG2N-1:0] idx_next;
  logic [7:0]       gap_cnt, gap_next;
  logic             load, accept;
  logic             issue, issue_sop, issue_eop, issue_zero, abort;
  logic [LOG2N-1:0] out_cnt;
  logic             out_open, out_err, out_frame_ok;

  // The output stage may take a new beat when empty or when the core drains it this cycle.
  assign load     = !core_valid || core_ready;
  assign in_ready = load && (state != PAD);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_next = state;
    idx_next   = in_idx;
    gap_next   = gap_cnt;
    issue      = 1'b0;
    issue_sop  = 1'b0;
    issue_eop  = 1'b0;
    issue_zero = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        gap_next = '0;
        if (accept) begin
          issue      = 1'b1;
          issue_sop  = 1'b1;
          idx_next   = LOG2N'(1);
          state_next = RUN;
        end
      end
      RUN: begin
        if (accept) begin
          issue    = 1'b1;
          gap_next = '0;
          if (in_idx == LAST_IDX) begin
            issue_eop  = 1'b1;
            idx_next   = '0;
            state_next = IDLE;
          end else begin
            idx_next = in_idx + 1'b1;
          end
        end else if (!in_valid && load) begin
          // Only genuinely idle cycles count; core stalls never do.
          if (gap_cnt == GAP_LAST) begin
            abort    = 1'b1;
            gap_next = '0;
`ifdef FFT_FRAME_PAD_EN
            state_next = PAD;
`else
            state_next = IDLE;
            idx_next   = '0;
`endif
          end else begin
            gap_next = gap_cnt + 8'd1;
          end
        end
      end
`ifdef FFT_FRAME_PAD_EN
      PAD: begin
        if (load) begin
          issue      = 1'b1;
          issue_zero = 1'b1;
          if (in_idx == LAST_IDX) begin
            issue_eop  = 1'b1;
            idx_next   = '0;
            state_next = IDLE;
          end else begin
            idx_next = in_idx + 1'b1;
          end
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      in_idx       <= '0;
      gap_cnt      <= '0;
      core_valid   <= 1'b0;
      core_sop     <= 1'b0;
      core_eop     <= 1'b0;
      core_real    <= '0;
      core_imag    <= '0;
      core_inverse <= 1'b0;
    end else begin
      state   <= state_next;
      in_idx  <= idx_next;
      gap_cnt <= gap_next;
      if (load) begin
        core_valid <= issue;
        core_sop   <= issue_sop;
        core_eop   <= issue_eop;
        if (issue) begin
          core_real <= issue_zero ? '0 : in_real;
          core_imag <= issue_zero ? '0 : in_imag;
        end
      end
      if (state == IDLE && accept) core_inverse <= inverse;
    end
  end

  // Output side: a sop beat is always bin 0, every other beat continues the running count.
  assign out_idx      = (src_valid && src_sop) ? '0 : out_cnt;
  assign out_err      = src_valid && ((src_eop && out_idx != LAST_IDX) || (src_sop && out_open));
  assign out_frame_ok = src_valid && src_eop && (out_idx == LAST_IDX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_cnt     <= '0;
      out_open    <= 1'b0;
      frame_err   <= 1'b0;
      frames_done <= '0;
    end else begin
      frame_err <= abort || out_err;
      if (src_valid) begin
        out_cnt  <= out_idx + 1'b1;
        out_open <= src_eop ? 1'b0 : (src_sop ? 1'b1 : out_open);
      end
      if (out_frame_ok) frames_done <= frames_done + 16'd1;
    end
  end
endmodule

// File: doc/fft_stream_framer.md
# fft_stream_framer

Parametrised framing controller between a sample source and the streaming FFT/IFFT core. Generalises the fixed 1024-point, 8-bit framer:
- configurable data width and transform length;
- honours core backpressure (`core_ready`);
- selects forward/inverse per frame;
- detects input gaps mid-frame and recovers from them;
- checks and indexes the core output stream.

## Interface
Parameters:
- DW, 8 — real/imag sample width
- LOG2N, 10 — log2 transform length; N = 2^LOG2N
- GAP_MAX, 4 — consecutive idle cycles tolerated mid-frame before abort (1..255)

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream sample valid
- in_ready  out  1  upstream sample accepted when in_valid && in_ready
- in_real / in_imag  in  DW  upstream sample
- inverse  in  1  transform direction request; sampled at frame start
- core_valid  out  1  sample valid to core
- core_sop / core_eop  out  1  frame start / end to core
- core_real / core_imag  out  DW  sample to core
- core_inverse  out  1  direction held for the whole frame
- core_ready  in  1  core accepts sample when core_valid && core_ready
- src_valid / src_sop / src_eop  in  1  core output strobes
- out_idx  out  LOG2N  output bin index of the current src beat
- in_idx  out  LOG2N  index of the next sample to be issued
- frame_err  out  1  one-cycle pulse: input abort or output framing error
- frames_done  out  16  count of complete output frames, wraps at 2^16

## Operation
- One output register stage holds core_valid/sop/eop/real/imag.
  - Stage loads when empty or core_ready=1.
  - in_ready = (stage empty || core_ready) && state != PAD.
- States:
  - IDLE:
    - First accepted sample → RUN.
    - That sample carries core_sop=1 and has index 0.
    - core_inverse <= inverse.
  - RUN:
    - Each accepted sample increments in_idx.
    - The sample at index N-1 carries core_eop=1, then → IDLE with in_idx=0.
    - gap_cnt counts cycles with in_valid=0; it resets on any accepted sample.
    - gap_cnt reaching GAP_MAX → abort (see Configuration).
    - Cycles stalled by core_ready=0 do not count toward gap_cnt.
  - PAD: exists only with the macro; described under Configuration.
- N=1 (LOG2N=0) is unsupported; LOG2N ≥ 2.
- Output side:
  - out_idx resets to 0 on a src_valid beat with src_sop=1.
  - Otherwise out_idx increments on each src_valid beat, wrapping at N.
  - src_eop at out_idx==N-1 increments frames_done.
  - frame_err pulses if src_eop arrives at out_idx≠N-1, or src_sop arrives while the output frame is still open.
- Input abort and output error in the same cycle produce a single frame_err pulse.

## Timing
- Reset values:
  - in_ready=1; core_valid=0, core_sop=0, core_eop=0; core_real/imag=0; core_inverse=0.
  - in_idx=0, out_idx=0, frame_err=0, frames_done=0.
  - State IDLE.
- Latency: accepted sample appears on core_* the next cycle.
- While core_valid=1 && core_ready=0, all core_* outputs hold stable.
- in_ready falls combinationally with core_ready only when the stage is full.
- reset_n asserted mid-frame:
  - All state clears immediately.
  - core_valid drops asynchronously.
  - No eop is emitted for the partial frame.
- frame_err is registered and asserts one cycle after the triggering event.

## Configuration
- FFT_FRAME_PAD_EN defined — gap abort enters PAD:
  - in_ready=0 while in PAD.
  - Issues zero samples (core_real=core_imag=0) with core_valid=1, obeying core_ready, until index N-1.
  - Index N-1 carries core_eop; then → IDLE.
  - frame_err pulses once, on entry to PAD.
  - The core never sees a short frame.
- FFT_FRAME_PAD_EN undefined — gap abort:
  - Pulses frame_err.
  - Returns to IDLE with in_idx=0 and emits no eop.
  - The next sample restarts the frame with core_sop=1.

## Test plan
- LOG2N=4, continuous in_valid, core_ready=1, 32 samples → sop on samples 0 and 16, eop on 15 and 31; core_inverse follows inverse sampled at each sop.
- Random core_ready with 50% duty over 16 samples → no sample lost or duplicated, core_* stable while stalled, exactly one sop and one eop.
- Input stops after sample 5, GAP_MAX=4:
  - with FFT_FRAME_PAD_EN → 10 zero samples follow, eop on the last, one frame_err;
  - without FFT_FRAME_PAD_EN → frame_err, next sample has sop and in_idx restarts at 0.
- Gap of exactly GAP_MAX-1 idle cycles mid-frame → no abort, frame completes normally.
- src stream with src_eop at out_idx=7 (N=16) → frame_err pulse, frames_done unchanged; a following correct 16-beat frame increments frames_done to 1.
- reset_n pulsed at in_idx=9 → all outputs return to reset values; next frame starts with sop and in_idx=0.
